// File: rtl/demux8_pkg.sv
// Shared constants, FSM state type and select decode for the demux8 collector.
package demux8_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    localparam logic [NCH-1:0] ALL_WRITTEN = 8'hFF;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NCH-1:0] v;
        v = {{(NCH-1){1'b0}}, 1'b1} << s;
        return v;
    endfunction

endpackage

// File: rtl/demux8_if.sv
// Demux-side inputs, frame handshake and error flags of the collector.
interface demux8_if;
    import demux8_pkg::*;

    logic                 a, b, c, d, e, f, g, h;
    logic                 x0, x1, x2;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH-1:0]       frame;
    logic                 out_valid;
    logic                 out_ready;
    logic                 glitch_err;
    logic                 dup_err;
    logic                 err_clr;

    modport master (
        output a, b, c, d, e, f, g, h, x0, x1, x2, in_valid, out_ready, err_clr,
        input  in_ready, frame, out_valid, glitch_err, dup_err
    );

    modport slave (
        input  a, b, c, d, e, f, g, h, x0, x1, x2, in_valid, out_ready, err_clr,
        output in_ready, frame, out_valid, glitch_err, dup_err
    );

endinterface

// File: rtl/demux8_check.sv
// Demux integrity decode: selected channel bit and any activity on non-selected outputs.
module demux8_check
    import demux8_pkg::*;
(
    input  logic [NCH-1:0]   ch,
    input  logic [SEL_W-1:0] s,
    output logic             bit_sel,
    output logic             glitch
);

    assign bit_sel = ch[s];
    assign glitch  = |(ch & ~onehot(s));

endmodule

// File: rtl/demux8_collector.sv
// Assembles one bit per demux channel into an 8-bit frame and offers it over valid/ready,
// flagging demux glitches and duplicate channel writes.
module demux8_collector
    import demux8_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    demux8_if.slave  bus
);

    state_t             state_r, state_next_s;
    logic [NCH-1:0]     asm_r, asm_next_s;
    logic [NCH-1:0]     wr_mask_r, wr_mask_next_s;
    logic [NCH-1:0]     frame_r, frame_next_s;
    logic               out_valid_r, out_valid_next_s;
    logic               glitch_r, glitch_next_s;
    logic               dup_r, dup_next_s;

    logic [NCH-1:0]     ch_s;
    logic [SEL_W-1:0]   sel_s;
    logic [NCH-1:0]     sel_oh_s;
    logic               bit_sel_s, glitch_s;
    logic               accept_s, complete_s, out_free_s;
    logic [NCH-1:0]     mask_upd_s, asm_upd_s;

    assign ch_s     = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
    assign sel_s    = {bus.x2, bus.x1, bus.x0};
    assign sel_oh_s = onehot(sel_s);

    demux8_check u_check (
        .ch      (ch_s),
        .s       (sel_s),
        .bit_sel (bit_sel_s),
        .glitch  (glitch_s)
    );

    assign accept_s   = bus.in_valid && (state_r == COLLECT);
    assign mask_upd_s = wr_mask_r | sel_oh_s;
    assign asm_upd_s  = (asm_r & ~sel_oh_s) | ({NCH{bit_sel_s}} & sel_oh_s);
    assign complete_s = accept_s && (mask_upd_s == ALL_WRITTEN);
    assign out_free_s = !out_valid_r || bus.out_ready;

    // Next-state, assembly and output-register decode.
    always_comb begin
        state_next_s     = state_r;
        asm_next_s       = asm_r;
        wr_mask_next_s   = wr_mask_r;
        frame_next_s     = frame_r;
        out_valid_next_s = out_valid_r && !bus.out_ready;
        case (state_r)
            COLLECT: begin
                if (complete_s) begin
                    if (out_free_s) begin
                        frame_next_s     = asm_upd_s;
                        out_valid_next_s = 1'b1;
                        asm_next_s       = {NCH{1'b0}};
                        wr_mask_next_s   = {NCH{1'b0}};
                    end else begin
                        // Output still occupied: park the finished frame in asm.
                        state_next_s     = FULL;
                        asm_next_s       = asm_upd_s;
                        wr_mask_next_s   = ALL_WRITTEN;
                    end
                end else if (accept_s) begin
                    asm_next_s     = asm_upd_s;
                    wr_mask_next_s = mask_upd_s;
                end else begin
                    asm_next_s     = asm_r;
                    wr_mask_next_s = wr_mask_r;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_next_s     = COLLECT;
                    frame_next_s     = asm_r;
                    out_valid_next_s = 1'b1;
                    asm_next_s       = {NCH{1'b0}};
                    wr_mask_next_s   = {NCH{1'b0}};
                end else begin
                    state_next_s     = FULL;
                end
            end
            default: begin
                state_next_s     = COLLECT;
                asm_next_s       = {NCH{1'b0}};
                wr_mask_next_s   = {NCH{1'b0}};
            end
        endcase
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_comb begin
        if (accept_s && glitch_s) begin
            glitch_next_s = 1'b1;
        end else if (bus.err_clr) begin
            glitch_next_s = 1'b0;
        end else begin
            glitch_next_s = glitch_r;
        end
        if (accept_s && wr_mask_r[sel_s]) begin
            dup_next_s = 1'b1;
        end else if (bus.err_clr) begin
            dup_next_s = 1'b0;
        end else begin
            dup_next_s = dup_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= COLLECT;
            asm_r       <= {NCH{1'b0}};
            wr_mask_r   <= {NCH{1'b0}};
            frame_r     <= {NCH{1'b0}};
            out_valid_r <= 1'b0;
            glitch_r    <= 1'b0;
            dup_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            asm_r       <= asm_next_s;
            wr_mask_r   <= wr_mask_next_s;
            frame_r     <= frame_next_s;
            out_valid_r <= out_valid_next_s;
            glitch_r    <= glitch_next_s;
            dup_r       <= dup_next_s;
        end
    end

    assign bus.in_ready   = (state_r == COLLECT);
    assign bus.frame      = frame_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.glitch_err = glitch_r;
    assign bus.dup_err    = dup_r;

endmodule

// File: tb/tb_demux8_collector.sv
// Scoreboard bench for demux8_collector: directed scenarios plus random traffic.
module tb_demux8_collector;
    import demux8_pkg::*;

    logic clk = 1'b0;
    logic rst;

    demux8_if bus ();

    demux8_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frames that have completed but not yet been taken by the consumer, oldest first.
    logic [7:0] exp_q[$];

    // Reference model: bits gathered so far, which channels were seen, frames outstanding.
    logic [7:0] m_bits;
    logic [7:0] m_seen;
    int         m_pending;
    logic       m_glitch;
    logic       m_dup;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        m_bits    = 8'h00;
        m_seen    = 8'h00;
        m_pending = 0;
        m_glitch  = 1'b0;
        m_dup     = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_update(input logic v, input logic [2:0] s, input logic [7:0] ch,
                                         input logic ordy, input logic eclr);
        logic acc, drn, gset, dset;
        acc  = v && (m_pending < 2);
        drn  = ordy && (m_pending > 0);
        gset = 1'b0;
        dset = 1'b0;
        if (acc) begin
            gset      = (ch & ~(8'd1 << s)) != 8'd0;
            dset      = m_seen[s];
            m_bits[s] = ch[s];
            m_seen[s] = 1'b1;
            if (m_seen == 8'hFF) begin
                exp_q.push_back(m_bits);
                m_pending++;
                m_bits = 8'h00;
                m_seen = 8'h00;
            end
        end
        if (drn) m_pending--;
        m_glitch = gset | (m_glitch & ~eclr);
        m_dup    = dset | (m_dup & ~eclr);
    endfunction

    // One clock of stimulus; returns #1 after the edge with the per-cycle status checked.
    task automatic drive(input logic v, input int s, input logic d, input logic [7:0] gm,
                         input logic ordy, input logic eclr);
        logic [7:0] ch;
        logic [2:0] sv;
        sv = s[2:0];
        ch = gm;
        if (d) ch[sv] = 1'b1;
        {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = ch;
        {bus.x2, bus.x1, bus.x0} = sv;
        bus.in_valid  = v;
        bus.out_ready = ordy;
        bus.err_clr   = eclr;
        @(posedge clk);
        model_update(v, sv, ch, ordy, eclr);
        #1;
        check1("in_ready", bus.in_ready, m_pending < 2);
        check1("out_valid", bus.out_valid, m_pending > 0);
        check1("glitch_err", bus.glitch_err, m_glitch);
        check1("dup_err", bus.dup_err, m_dup);
    endtask

    task automatic frame_seq(input int order[8], input logic [7:0] data, input logic ordy);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, order[i], data[order[i]], 8'h00, ordy, 1'b0);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, 1'b0, 8'h00, ordy, 1'b0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check1({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check8({tag, "_frame"}, bus.frame, 8'h00);
        check1({tag, "_glitch"}, bus.glitch_err, 1'b0);
        check1({tag, "_dup"}, bus.dup_err, 1'b0);
    endtask

    // Scoreboard monitor: every presented frame must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got frame %h expected no valid frame at %0t", bus.frame, $time);
            end else begin
                check8(bus.out_ready ? "sb_frame" : "sb_hold", bus.frame, exp_q[0]);
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int inorder[8];
        int ooo[8];
        logic [7:0] rdata;
        int free_ch[$];
        int s;

        inorder = '{0, 1, 2, 3, 4, 5, 6, 7};
        ooo     = '{7, 3, 0, 5, 1, 6, 2, 4};
        model_clear();
        {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = 8'h00;
        {bus.x2, bus.x1, bus.x0} = 3'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        rst = 1'b1;
        #12;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean in-order frame
        frame_seq(inorder, 8'h4D, 1'b1);
        check8("clean_frame", bus.frame, 8'h4D);
        check1("clean_valid", bus.out_valid, 1'b1);
        idle(1, 1'b1);

        // Out-of-order select sequence
        frame_seq(ooo, 8'h44, 1'b1);
        check8("ooo_frame", bus.frame, 8'h44);
        idle(1, 1'b1);

        // Backpressure: two frames queue up, collector stalls
        frame_seq(inorder, 8'hFF, 1'b0);
        frame_seq(inorder, 8'h0F, 1'b0);
        check1("bp_in_ready", bus.in_ready, 1'b0);
        check8("bp_hold", bus.frame, 8'hFF);
        drive(1'b1, 3, 1'b1, 8'h80, 1'b0, 1'b0);
        check1("bp_ignored_glitch", bus.glitch_err, 1'b0);
        drive(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0);
        check8("bp_second", bus.frame, 8'h0F);
        check1("bp_valid", bus.out_valid, 1'b1);
        check1("bp_ready_back", bus.in_ready, 1'b1);
        idle(1, 1'b1);
        check1("bp_drained", bus.out_valid, 1'b0);

        // Glitch: a and c high with select 2
        drive(1'b1, 2, 1'b1, 8'h01, 1'b1, 1'b0);
        check1("glitch_set", bus.glitch_err, 1'b1);
        drive(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        check1("glitch_clr", bus.glitch_err, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k != 2) drive(1'b1, k, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check8("glitch_frame", bus.frame, 8'h04);
        drive(1'b1, 0, 1'b0, 8'h02, 1'b1, 1'b1);
        check1("glitch_set_wins", bus.glitch_err, 1'b1);
        drive(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Duplicate write to channel 4 (channel 0 already holds a bit)
        drive(1'b1, 4, 1'b1, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 4, 1'b0, 8'h00, 1'b1, 1'b0);
        check1("dup_set", bus.dup_err, 1'b1);
        for (int k = 1; k < 8; k++) begin
            if (k != 4) drive(1'b1, k, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check1("dup_complete", bus.out_valid, 1'b1);
        check8("dup_frame", bus.frame, 8'h00);
        drive(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) drive(1'b1, k, 1'b0, 8'h00, 1'b1, 1'b0);
        check1("dup_no_early", bus.out_valid, 1'b0);
        drive(1'b1, 7, 1'b0, 8'h00, 1'b1, 1'b0);
        check1("dup_late_valid", bus.out_valid, 1'b1);
        idle(1, 1'b1);

        // Reset with a pending frame and a partial one
        frame_seq(inorder, 8'hAA, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b1, k, 1'b1, 8'h10, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #2;
        model_clear();
        check_reset_values("midrst");
        rst = 1'b0;
        rdata = 8'($urandom());
        frame_seq(ooo, rdata, 1'b1);
        check8("post_reset_frame", bus.frame, rdata);
        idle(1, 1'b1);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            free_ch.delete();
            for (int k = 0; k < 8; k++) if (!m_seen[k]) free_ch.push_back(k);
            if (free_ch.size() > 0 && $urandom_range(0, 7) != 0)
                s = free_ch[$urandom_range(0, free_ch.size() - 1)];
            else
                s = $urandom_range(0, 7);
            drive($urandom_range(0, 3) != 0, s, 1'($urandom()),
                  ($urandom_range(0, 15) == 0) ? 8'($urandom()) : 8'h00,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        idle(4, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d frames left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
